// File: rtl/debug_pkg.sv
// Shared constants and state encoding for the host debug unit.
package debug_pkg;

    localparam logic [7:0]  CMD_LOAD       = 8'h4C;
    localparam logic [7:0]  CMD_STEP       = 8'h53;
    localparam logic [7:0]  CMD_RUN        = 8'h43;
    localparam logic [31:0] HALT_WORD_DEF  = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD = 4;
    localparam int          REG_WORDS      = 32;
    localparam int          MEM_WORDS      = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STEP,
        ST_RUN,
        ST_DUMP_SET,
        ST_DUMP_LATCH,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

endpackage

// File: rtl/debug_unit_word_serializer.sv
// Holds one dump word and presents it a byte at a time, MSB first,
// advancing on each transmitter handshake.
module word_serializer #(
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    input  logic              shift,
    output logic [BYTE_W-1:0] data_byte,
    output logic              last
);

    localparam int BYTES = WORD_W / BYTE_W;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [WORD_W-1:0] word_q;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            cnt    <= '0;
        end else if (load) begin
            word_q <= word;
            cnt    <= '0;
        end else if (shift) begin
            word_q <= word_q << BYTE_W;
            cnt    <= cnt + CNT_W'(1);
        end
    end

    assign data_byte = word_q[WORD_W-1 -: BYTE_W];
    assign last      = (cnt == CNT_W'(BYTES - 1));

endmodule

// File: rtl/debug_unit.sv
// Host debug controller: program load, step/run control and state dump over UART.
// DEBUG_MEM_DUMP_EN adds the 32 data-memory words to every dump.
module debug_unit
    import debug_pkg::*;
#(
    parameter int                 INST_SZ   = 32,
    parameter int                 PC_SZ     = 32,
    parameter int                 REG_SZ    = 5,
    parameter int                 BYTE_SZ   = 8,
    parameter logic [INST_SZ-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_done,
    input  logic [BYTE_SZ-1:0] i_rx_data,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [BYTE_SZ-1:0] o_tx_data,
    input  logic [PC_SZ-1:0]   i_pc,
    input  logic [INST_SZ-1:0] i_reg,
    input  logic [INST_SZ-1:0] i_mem,
    input  logic               i_halt,
    output logic               o_write,
    output logic               o_enable,
    output logic [INST_SZ-1:0] o_instruction,
    output logic [REG_SZ-1:0]  o_debug_addr,
    output logic               o_busy
);

`ifdef DEBUG_MEM_DUMP_EN
    localparam int         DUMP_WORDS = 1 + REG_WORDS + MEM_WORDS;
    localparam logic [6:0] MEM_FIRST  = 7'(REG_WORDS + 1);
`else
    localparam int         DUMP_WORDS = 1 + REG_WORDS;
`endif
    localparam logic [6:0] LAST_WORD  = 7'(DUMP_WORDS - 1);

    state_t                     state, state_n;
    logic [1:0]                 byte_cnt;
    logic [INST_SZ-BYTE_SZ-1:0] shift_q;
    logic [INST_SZ-1:0]         instr_q;
    logic                       write_q;
    logic                       halted;
    logic [6:0]                 word_cnt;
    logic [REG_SZ-1:0]          addr_q;

    logic                       rx_ok;
    logic [INST_SZ-1:0]         load_word;
    logic [INST_SZ-1:0]         pc_word;
    logic [INST_SZ-1:0]         dump_src;
    logic                       ser_load, ser_shift, ser_last;
    logic [INST_SZ-1:0]         ser_word;
    logic                       dump_start, word_done;

    // A byte colliding with a tx handshake is only honoured mid-load.
    assign rx_ok     = i_rx_done && (state == ST_LOAD || !i_tx_done);
    assign load_word = {shift_q, i_rx_data};
    assign pc_word   = INST_SZ'(i_pc);

`ifdef DEBUG_MEM_DUMP_EN
    assign dump_src = (word_cnt >= MEM_FIRST) ? i_mem : i_reg;
`else
    logic unused_mem;
    assign dump_src   = i_reg;
    assign unused_mem = ^i_mem;
`endif

    always_comb begin
        state_n   = state;
        ser_load  = 1'b0;
        ser_word  = pc_word;
        ser_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rx_ok) begin
                    case (i_rx_data)
                        CMD_LOAD: state_n = ST_LOAD;
                        CMD_STEP, CMD_RUN: begin
                            if (halted) begin
                                state_n  = ST_SEND;
                                ser_load = 1'b1;
                            end else begin
                                state_n = (i_rx_data == CMD_STEP) ? ST_STEP : ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_LOAD: begin
                if (rx_ok && byte_cnt == 2'd3 && load_word == HALT_WORD)
                    state_n = ST_IDLE;
            end
            ST_STEP: begin
                state_n  = ST_SEND;
                ser_load = 1'b1;
            end
            ST_RUN: begin
                if (i_halt) begin
                    state_n  = ST_SEND;
                    ser_load = 1'b1;
                end
            end
            ST_DUMP_SET: state_n = ST_DUMP_LATCH;
            ST_DUMP_LATCH: begin
                state_n  = ST_SEND;
                ser_load = 1'b1;
                ser_word = dump_src;
            end
            ST_SEND: state_n = ST_WAIT_TX;
            ST_WAIT_TX: begin
                if (i_tx_done) begin
                    ser_shift = 1'b1;
                    if (!ser_last)
                        state_n = ST_SEND;
                    else if (word_cnt == LAST_WORD)
                        state_n = ST_IDLE;
                    else
                        state_n = ST_DUMP_SET;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign dump_start = ser_load && (state != ST_DUMP_LATCH);
    assign word_done  = (state == ST_WAIT_TX) && i_tx_done && ser_last;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            shift_q  <= '0;
            instr_q  <= '0;
            write_q  <= 1'b0;
            halted   <= 1'b0;
            word_cnt <= '0;
            addr_q   <= '0;
        end else begin
            state   <= state_n;
            write_q <= 1'b0;
            if (state == ST_IDLE && rx_ok && i_rx_data == CMD_LOAD) begin
                halted   <= 1'b0;
                byte_cnt <= '0;
            end
            if ((state == ST_STEP || state == ST_RUN) && i_halt)
                halted <= 1'b1;
            if (state == ST_LOAD && rx_ok) begin
                shift_q  <= load_word[INST_SZ-BYTE_SZ-1:0];
                byte_cnt <= byte_cnt + 2'd1;
                if (byte_cnt == 2'd3) begin
                    instr_q <= load_word;
                    write_q <= 1'b1;
                end
            end
            // Word 0 is the PC; the address only starts counting from the first register.
            if (dump_start) begin
                word_cnt <= '0;
                addr_q   <= '0;
            end else if (word_done) begin
                word_cnt <= word_cnt + 7'd1;
                if (word_cnt != 7'd0)
                    addr_q <= addr_q + REG_SZ'(1);
            end
        end
    end

    word_serializer #(
        .WORD_W (INST_SZ),
        .BYTE_W (BYTE_SZ)
    ) u_ser (
        .clk       (i_clk),
        .rst       (i_reset),
        .load      (ser_load),
        .word      (ser_word),
        .shift     (ser_shift),
        .data_byte (o_tx_data),
        .last      (ser_last)
    );

    assign o_tx_start    = (state == ST_SEND);
    assign o_enable      = (state == ST_STEP) || (state == ST_RUN);
    assign o_write       = write_q;
    assign o_instruction = instr_q;
    assign o_debug_addr  = addr_q;
    assign o_busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: stimulus queues expected writes and dump bytes,
// a monitor pops and compares whenever the DUT presents them.
module tb_debug_unit;

`ifdef DEBUG_MEM_DUMP_EN
    localparam int DUMP_BYTES = 260;
`else
    localparam int DUMP_BYTES = 132;
`endif

    logic        clk = 0;
    logic        i_reset = 1;
    logic        i_rx_done = 0;
    logic [7:0]  i_rx_data = 0;
    logic        i_tx_done = 0;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic [31:0] i_pc = 0;
    logic [31:0] i_reg, i_mem;
    logic        i_halt = 0;
    logic        o_write, o_enable, o_busy;
    logic [31:0] o_instruction;
    logic [4:0]  o_debug_addr;

    logic [31:0] regs [32];
    logic [31:0] mem  [32];

    logic [31:0] exp_wr [$];
    logic [7:0]  exp_tx [$];
    int checks = 0, errors = 0;
    int tx_cnt = 0, wr_seen = 0, en_cycles = 0;
    logic en_after, st_after;

    always #5 clk = ~clk;

    assign i_reg = regs[o_debug_addr];
    assign i_mem = mem[o_debug_addr];

    debug_unit dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_rx_done(i_rx_done), .i_rx_data(i_rx_data),
        .i_tx_done(i_tx_done), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .i_pc(i_pc), .i_reg(i_reg), .i_mem(i_mem), .i_halt(i_halt),
        .o_write(o_write), .o_enable(o_enable), .o_instruction(o_instruction),
        .o_debug_addr(o_debug_addr), .o_busy(o_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_tx.push_back(w[b*8 +: 8]);
    endfunction

    // Reference dump: PC, every register, then (optionally) every memory word.
    function automatic void push_dump();
        push_word(i_pc);
        for (int r = 0; r < 32; r++) push_word(regs[r]);
`ifdef DEBUG_MEM_DUMP_EN
        for (int m = 0; m < 32; m++) push_word(mem[m]);
`endif
    endfunction

    function automatic void randomize_core();
        i_pc = $urandom;
        for (int i = 0; i < 32; i++) begin
            regs[i] = $urandom;
            mem[i]  = $urandom;
        end
    endfunction

    task automatic send_rx(input logic [7:0] b, input int gap);
        @(negedge clk);
        i_rx_data = b;
        i_rx_done = 1;
        @(negedge clk);
        en_after  = o_enable;
        st_after  = o_tx_start;
        i_rx_done = 0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) send_rx(w[b*8 +: 8], $urandom_range(0, 3));
    endtask

    task automatic wait_dump(input int base);
        int i;
        for (i = 0; i < 6000; i++) begin
            if (tx_cnt == base + DUMP_BYTES && !o_busy) break;
            @(negedge clk);
        end
        chk("dump_byte_count", tx_cnt - base, DUMP_BYTES);
        chk("dump_queue_drained", exp_tx.size(), 0);
        chk("dump_returns_idle", o_busy, 0);
    endtask

    // UART transmitter model: acknowledges each start after a random delay.
    initial begin
        forever begin
            @(negedge clk);
            i_tx_done = 0;
            if (o_tx_start) begin
                int dup = 0;
                repeat ($urandom_range(1, 4)) begin
                    @(negedge clk);
                    if (o_tx_start) dup++;
                end
                chk("tx_start_once", dup, 0);
                i_tx_done = 1;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (o_enable) en_cycles++;
            if (o_write) begin
                wr_seen++;
                chk("write_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) chk("write_word", o_instruction, exp_wr.pop_front());
            end
            if (o_tx_start) begin
                tx_cnt++;
                chk("tx_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) chk("tx_byte", o_tx_data, exp_tx.pop_front());
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, len;
        logic [31:0] w;
        for (int i = 0; i < 32; i++) begin regs[i] = 0; mem[i] = 0; end

        repeat (3) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_enable", o_enable, 0);
        chk("rst_write", o_write, 0);
        chk("rst_tx_start", o_tx_start, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_instruction", o_instruction, 0);
        chk("rst_debug_addr", o_debug_addr, 0);
        i_reset = 0;

        // Reset after two program bytes must discard the partial word.
        send_rx(8'h4C, 1);
        send_rx(8'h12, 1);
        send_rx(8'h34, 1);
        chk("midload_busy", o_busy, 1);
        i_reset = 1;
        @(negedge clk);
        chk("midload_rst_busy", o_busy, 0);
        i_reset = 0;
        repeat (3) @(negedge clk);
        chk("midload_no_write", wr_seen, 0);

        exp_wr.push_back(32'h2001_0005);
        exp_wr.push_back(32'hFFFF_FFFF);
        send_rx(8'h4C, 1);
        send_word(32'h2001_0005);
        send_word(32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        chk("load_write_count", wr_seen, 2);
        chk("load_back_idle", o_busy, 0);

        send_rx(8'h4C, 0);
        for (int k = 0; k < 3; k++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            exp_wr.push_back(w);
            send_word(w);
        end
        exp_wr.push_back(32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        chk("rand_load_writes", wr_seen, 6);
        chk("rand_load_idle", o_busy, 0);

        // Single step: one enable cycle then a full dump.
        randomize_core();
        i_pc = 32'd4;
        push_dump();
        base = tx_cnt;
        en_cycles = 0;
        send_rx(8'h53, 0);
        chk("step_enable_next_cycle", en_after, 1);
        wait_dump(base);
        chk("step_enable_cycles", en_cycles, 1);

        // Continuous run with halt raised so enable is sampled high for 10 cycles.
        randomize_core();
        push_dump();
        base = tx_cnt;
        en_cycles = 0;
        send_rx(8'h43, 0);
        chk("run_enable_next_cycle", en_after, 1);
        repeat (9) @(negedge clk);
        i_halt = 1;
        wait_dump(base);
        chk("run_enable_cycles", en_cycles, 10);

        // Halted: step goes straight to dump.
        randomize_core();
        push_dump();
        base = tx_cnt;
        en_cycles = 0;
        send_rx(8'h53, 0);
        chk("halted_step_no_enable", en_after, 0);
        chk("halted_step_dump_now", st_after, 1);
        wait_dump(base);
        chk("halted_step_enable_cycles", en_cycles, 0);

        // Unknown byte in IDLE, then stray bytes during a dump.
        send_rx(8'h58, 2);
        chk("unknown_cmd_idle", o_busy, 0);
        randomize_core();
        push_dump();
        base = tx_cnt;
        en_cycles = 0;
        send_rx(8'h43, 0);
        chk("halted_run_dump_now", st_after, 1);
        while (tx_cnt < base + 8) @(negedge clk);
        send_rx(8'h4C, 3);
        send_rx(8'h58, 3);
        wait_dump(base);
        chk("dump_rx_no_write", wr_seen, 6);
        chk("halted_run_enable_cycles", en_cycles, 0);

        // Load clears the halted flag so stepping executes again.
        i_halt = 0;
        send_rx(8'h4C, 0);
        w = $urandom & 32'h7FFF_FFFF;
        exp_wr.push_back(w);
        send_word(w);
        exp_wr.push_back(32'hFFFF_FFFF);
        send_word(32'hFFFF_FFFF);
        randomize_core();
        push_dump();
        base = tx_cnt;
        en_cycles = 0;
        send_rx(8'h53, 0);
        chk("reload_step_enable", en_after, 1);
        wait_dump(base);
        chk("reload_step_cycles", en_cycles, 1);

        len = $urandom_range(2, 15);
        randomize_core();
        push_dump();
        base = tx_cnt;
        en_cycles = 0;
        send_rx(8'h43, 0);
        repeat (len - 1) @(negedge clk);
        i_halt = 1;
        wait_dump(base);
        chk("rand_run_cycles", en_cycles, len);

        // Reset in the middle of a dump aborts it immediately.
        randomize_core();
        push_dump();
        base = tx_cnt;
        send_rx(8'h53, 0);
        while (tx_cnt < base + 10) @(negedge clk);
        #1 i_reset = 1;
        @(negedge clk);
        chk("middump_busy", o_busy, 0);
        chk("middump_debug_addr", o_debug_addr, 0);
        chk("middump_tx_data", o_tx_data, 0);
        exp_tx.delete();
        base = tx_cnt;
        repeat (10) @(negedge clk);
        i_reset = 0;
        repeat (10) @(negedge clk);
        chk("middump_no_more_tx", tx_cnt, base);
        chk("all_writes_seen", exp_wr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
